uart_tx: RTL

UART transmitter that serialises parallel words onto a single line as start bit, LSB-first data, optional parity and 1 or 2 stop bits. It pairs with uart_rx on the peripheral side of the SoC and shares its baud tick (one tick_i pulse per bit period, from the common baud generator). Words enter through a valid/ready handshake into a one-deep holding register, so the next word can be queued while the current frame shifts out.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-FSM state encoding, parity helper, default width.
package uart_pkg;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned ParityMaxWidth   = 64;

    typedef enum logic [2:0] {
        Idle,
        StartBit,
        DataBits,
        ParityBit,
        StopBit
    } uart_state_e;

    // Zero-extended input leaves the XOR unchanged, so one width serves every DataWidth.
    function automatic logic calc_parity(input logic [ParityMaxWidth-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-deep holding register feeding a tick-paced frame shifter
// (start, LSB-first data, optional parity, 1 or 2 stop bits).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth = DefaultDataWidth,
    parameter int unsigned StopBits  = 1,
    parameter int unsigned ParityEn  = 0,
    parameter int unsigned ParityOdd = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 txd_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned     CntW     = $clog2(DataWidth + 1);
    localparam logic [CntW-1:0] LastCnt  = CntW'(DataWidth);
    // Stop counter holds (stop bits sent - 1), so one bit covers StopBits of 1 or 2.
    localparam logic            LastStop = (StopBits > 1);
    localparam logic            OddBit   = (ParityOdd != 0);

    uart_state_e          state_q, state_d;
    logic [DataWidth-1:0] hold_q, hold_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic                 hold_full_q, hold_full_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 txd_q, txd_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 load;

    assign accept = valid_i && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        stop_cnt_d  = stop_cnt_q;
        parity_d    = parity_q;
        txd_d       = txd_q;
        done_d      = 1'b0;
        load        = 1'b0;

        if (accept) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
        end

        if (tick_i) begin
            unique case (state_q)
                Idle: begin
                    txd_d = 1'b1;
                    load  = hold_full_q;
                end
                StartBit: begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = CntW'(1);
                    state_d = DataBits;
                end
                DataBits: begin
                    if (cnt_q == LastCnt) begin
                        if (ParityEn != 0) begin
                            txd_d   = parity_q;
                            state_d = ParityBit;
                        end else begin
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = StopBit;
                        end
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + CntW'(1);
                    end
                end
                ParityBit: begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = StopBit;
                end
                StopBit: begin
                    if (stop_cnt_q != LastStop) begin
                        txd_d      = 1'b1;
                        stop_cnt_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = Idle;
                        end
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = Idle;
                end
            endcase
        end

        // Shared by the Idle start and the gap-free StopBit restart; never coincides with accept.
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            parity_d    = calc_parity(ParityMaxWidth'(hold_q), OddBit);
            cnt_d       = '0;
            stop_cnt_d  = 1'b0;
            txd_d       = 1'b0;
            state_d     = StartBit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= Idle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            stop_cnt_q  <= 1'b0;
            parity_q    <= 1'b0;
            txd_q       <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            parity_q    <= parity_d;
            txd_q       <= txd_d;
            done_q      <= done_d;
        end
    end

    assign ready_o = !hold_full_q;
    assign txd_o   = txd_q;
    assign busy_o  = (state_q != Idle) || hold_full_q;
    assign done_o  = done_q;

endmodule
